disco_transfer_ctrl: RTL and testbench

- Block-copy (swap) controller between main memory and the simulated secondary disk (16-bit words, 15-bit disk address).
- Accepts one transfer command (direction, disk base, memory base, word count) and sequences word-by-word reads and writes on both sides.
- Sits between the CPU control unit / OS-call logic and the disk plus data-memory ports; it is the only disk master while busy.

---
 rtl/disco_pkg.sv | 20 ++
 rtl/disco_addr_gen.sv | 75 +++++++
 rtl/disco_transfer_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_disco_transfer_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disco_pkg.sv
// Shared definitions for the disk/memory block-copy controller.
package disco_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int DISK_ADDR_WIDTH = 15;
    localparam int MEM_ADDR_WIDTH  = 10;
    localparam int LEN_WIDTH       = 16;

    localparam logic DIR_DISK2MEM = 1'b0;
    localparam logic DIR_MEM2DISK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/disco_addr_gen.sv
// Wrapping disk/memory pointers and the words-done counter for one transfer.
// The *_nxt outputs expose the value the pointers take at the next edge so the
// controller can register its address outputs in the same cycle.
module disco_addr_gen
    import disco_pkg::*;
#(
    parameter int DISK_ADDR_WIDTH_P = DISK_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH_P  = MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH_P       = LEN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         step,
    input  logic [DISK_ADDR_WIDTH_P-1:0] disk_base,
    input  logic [MEM_ADDR_WIDTH_P-1:0]  mem_base,
    input  logic [LEN_WIDTH_P-1:0]       length,
    output logic [DISK_ADDR_WIDTH_P-1:0] disk_ptr_nxt,
    output logic [MEM_ADDR_WIDTH_P-1:0]  mem_ptr_nxt,
    output logic [LEN_WIDTH_P-1:0]       words_done,
    output logic                         last
);

    logic [DISK_ADDR_WIDTH_P-1:0] disk_ptr_q, disk_ptr_d;
    logic [MEM_ADDR_WIDTH_P-1:0]  mem_ptr_q, mem_ptr_d;
    logic [LEN_WIDTH_P-1:0]       len_q, len_d;
    logic [LEN_WIDTH_P-1:0]       cnt_q, cnt_d;
    logic [LEN_WIDTH_P:0]         cnt_inc_s;

    // Next pointer/counter values: load a new command or advance by one word.
    always_comb begin
        disk_ptr_d = disk_ptr_q;
        mem_ptr_d  = mem_ptr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        if (load) begin
            disk_ptr_d = disk_base;
            mem_ptr_d  = mem_base;
            len_d      = length;
            cnt_d      = {LEN_WIDTH_P{1'b0}};
        end else if (step) begin
            disk_ptr_d = disk_ptr_q + {{(DISK_ADDR_WIDTH_P-1){1'b0}}, 1'b1};
            mem_ptr_d  = mem_ptr_q + {{(MEM_ADDR_WIDTH_P-1){1'b0}}, 1'b1};
            cnt_d      = cnt_q + {{(LEN_WIDTH_P-1){1'b0}}, 1'b1};
        end else begin
            cnt_d      = cnt_q;
        end
    end

    // Last-word detect is evaluated one bit wider so a full-range length cannot wrap.
    always_comb begin
        cnt_inc_s = {1'b0, cnt_q} + {{LEN_WIDTH_P{1'b0}}, 1'b1};
        last      = (cnt_inc_s >= {1'b0, len_q});
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disk_ptr_q <= {DISK_ADDR_WIDTH_P{1'b0}};
            mem_ptr_q  <= {MEM_ADDR_WIDTH_P{1'b0}};
            len_q      <= {LEN_WIDTH_P{1'b0}};
            cnt_q      <= {LEN_WIDTH_P{1'b0}};
        end else begin
            disk_ptr_q <= disk_ptr_d;
            mem_ptr_q  <= mem_ptr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
        end
    end

    assign disk_ptr_nxt = disk_ptr_d;
    assign mem_ptr_nxt  = mem_ptr_d;
    assign words_done   = cnt_q;

endmodule

// File: rtl/disco_transfer_ctrl.sv
// Block-copy controller between main memory and the secondary disk.
// Each word takes READ (drive source address), WAIT (capture data) and WRITE
// (drive destination with a one-cycle strobe). All outputs are registered and
// computed from the next state, so they line up with the state they belong to.
module disco_transfer_ctrl
    import disco_pkg::*;
#(
    parameter int DATA_WIDTH_P      = DATA_WIDTH,
    parameter int DISK_ADDR_WIDTH_P = DISK_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH_P  = MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH_P       = LEN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         dir,
    input  logic [DISK_ADDR_WIDTH_P-1:0] disk_base,
    input  logic [MEM_ADDR_WIDTH_P-1:0]  mem_base,
    input  logic [LEN_WIDTH_P-1:0]       length,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [LEN_WIDTH_P-1:0]       words_done,
    output logic [DISK_ADDR_WIDTH_P-1:0] disk_addr,
    output logic [DATA_WIDTH_P-1:0]      disk_wdata,
    output logic                         disk_tr,
    input  logic [DATA_WIDTH_P-1:0]      disk_q,
    output logic [MEM_ADDR_WIDTH_P-1:0]  mem_addr,
    output logic [DATA_WIDTH_P-1:0]      mem_wdata,
    output logic                         mem_we,
    input  logic [DATA_WIDTH_P-1:0]      mem_q
);

    state_e                       state_q, state_d;
    logic                         dir_q, dir_d;
    logic [DATA_WIDTH_P-1:0]      buf_q, buf_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         aborted_q, aborted_d;
    logic [DISK_ADDR_WIDTH_P-1:0] disk_addr_q, disk_addr_d;
    logic [MEM_ADDR_WIDTH_P-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH_P-1:0]      disk_wdata_q, disk_wdata_d;
    logic [DATA_WIDTH_P-1:0]      mem_wdata_q, mem_wdata_d;
    logic                         disk_tr_q, disk_tr_d;
    logic                         mem_we_q, mem_we_d;

    logic                         load_s;
    logic                         step_s;
    logic                         last_s;
    logic [DISK_ADDR_WIDTH_P-1:0] disk_ptr_nxt_s;
    logic [MEM_ADDR_WIDTH_P-1:0]  mem_ptr_nxt_s;
    logic [LEN_WIDTH_P-1:0]       words_done_s;

    disco_addr_gen #(
        .DISK_ADDR_WIDTH_P (DISK_ADDR_WIDTH_P),
        .MEM_ADDR_WIDTH_P  (MEM_ADDR_WIDTH_P),
        .LEN_WIDTH_P       (LEN_WIDTH_P)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load_s),
        .step         (step_s),
        .disk_base    (disk_base),
        .mem_base     (mem_base),
        .length       (length),
        .disk_ptr_nxt (disk_ptr_nxt_s),
        .mem_ptr_nxt  (mem_ptr_nxt_s),
        .words_done   (words_done_s),
        .last         (last_s)
    );

    // Next state, data capture and next registered outputs.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        buf_d        = buf_q;
        aborted_d    = aborted_q;
        disk_addr_d  = disk_addr_q;
        mem_addr_d   = mem_addr_q;
        disk_wdata_d = disk_wdata_q;
        mem_wdata_d  = mem_wdata_q;
        load_s       = 1'b0;
        step_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_s    = 1'b1;
                    dir_d     = dir;
                    aborted_d = 1'b0;
                    if (length == {LEN_WIDTH_P{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dir_q == DIR_MEM2DISK) begin
                    buf_d = mem_q;
                end else begin
                    buf_d = disk_q;
                end
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The strobe for this word is already on the pins; it counts even on abort.
                step_s = 1'b1;
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_WRITE);
        done_d    = (state_d == ST_DONE);
        disk_tr_d = (state_d == ST_WRITE) && (dir_d == DIR_MEM2DISK);
        mem_we_d  = (state_d == ST_WRITE) && (dir_d == DIR_DISK2MEM);

        // Only the side in use moves; the other address holds its last value.
        if ((state_d == ST_READ) || (state_d == ST_WAIT)) begin
            if (dir_d == DIR_MEM2DISK) begin
                mem_addr_d = mem_ptr_nxt_s;
            end else begin
                disk_addr_d = disk_ptr_nxt_s;
            end
        end else if (state_d == ST_WRITE) begin
            if (dir_d == DIR_MEM2DISK) begin
                disk_addr_d  = disk_ptr_nxt_s;
                disk_wdata_d = buf_d;
            end else begin
                mem_addr_d  = mem_ptr_nxt_s;
                mem_wdata_d = buf_d;
            end
        end else begin
            disk_addr_d = disk_addr_q;
        end
    end

    // FSM state, data buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            buf_q        <= {DATA_WIDTH_P{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            disk_addr_q  <= {DISK_ADDR_WIDTH_P{1'b0}};
            mem_addr_q   <= {MEM_ADDR_WIDTH_P{1'b0}};
            disk_wdata_q <= {DATA_WIDTH_P{1'b0}};
            mem_wdata_q  <= {DATA_WIDTH_P{1'b0}};
            disk_tr_q    <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            buf_q        <= buf_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            disk_addr_q  <= disk_addr_d;
            mem_addr_q   <= mem_addr_d;
            disk_wdata_q <= disk_wdata_d;
            mem_wdata_q  <= mem_wdata_d;
            disk_tr_q    <= disk_tr_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign words_done = words_done_s;
    assign disk_addr  = disk_addr_q;
    assign disk_wdata = disk_wdata_q;
    assign disk_tr    = disk_tr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_disco_transfer_ctrl.sv
// Directed bench for disco_transfer_ctrl with behavioural disk/memory models
// and a queue of expected write strobes.
module tb_disco_transfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        dir;
    logic [14:0] disk_base;
    logic [9:0]  mem_base;
    logic [15:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] words_done;
    logic [14:0] disk_addr;
    logic [15:0] disk_wdata;
    logic        disk_tr;
    logic [15:0] disk_q;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_q;

    logic [15:0] disk_m [0:32767];
    logic [15:0] mem_m  [0:1023];

    logic        pl_en;
    logic        pl_disk;
    logic [14:0] pl_addr;
    logic [15:0] pl_data;

    typedef struct {
        bit is_disk;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t0    = 0;

    disco_transfer_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dir        (dir),
        .disk_base  (disk_base),
        .mem_base   (mem_base),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done),
        .disk_addr  (disk_addr),
        .disk_wdata (disk_wdata),
        .disk_tr    (disk_tr),
        .disk_q     (disk_q),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_q      (mem_q)
    );

    always #5 clk = ~clk;

    // Disk: combinational read. Memory: synchronous read. Both written on strobe or preload.
    assign disk_q = disk_m[disk_addr];

    always @(posedge clk) begin
        mem_q <= mem_m[mem_addr];
        if (mem_we) mem_m[mem_addr] <= mem_wdata;
        if (disk_tr) disk_m[disk_addr] <= disk_wdata;
        if (pl_en) begin
            if (pl_disk) disk_m[pl_addr] <= pl_data;
            else mem_m[pl_addr[9:0]] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_disk, input int addr, input int data, input int c);
        exp_t e;
        e.is_disk = is_disk;
        e.addr    = addr;
        e.data    = data;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit later and match any strobe against the queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (disk_tr || mem_we) begin
            chk("one_strobe", 32'(disk_tr & mem_we), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("wr_kind", 32'(disk_tr), 32'(e.is_disk));
                chk("wr_addr", disk_tr ? 32'(disk_addr) : 32'(mem_addr), e.addr);
                chk("wr_data", disk_tr ? 32'(disk_wdata) : 32'(mem_wdata), e.data);
                chk("wr_cycle", cyc - t0, e.cyc);
            end
        end
    endtask

    task automatic preload(input bit is_disk, input int addr, input int data);
        pl_en   = 1'b1;
        pl_disk = is_disk;
        pl_addr = 15'(addr);
        pl_data = 16'(data);
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_aborted"}, 32'(aborted), 32'd0);
        chk({tag, "_disk_tr"}, 32'(disk_tr), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_disk_addr"}, 32'(disk_addr), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_disk_wdata"}, 32'(disk_wdata), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_words_done"}, 32'(words_done), 32'd0);
    endtask

    // Issue one command and follow it to its done pulse; abort_cyc / sp_cyc = -1 disables.
    task automatic xfer(input string tag, input bit d, input int db, input int mb, input int len,
                        input bit abort_at_start, input int abort_cyc, input int sp_cyc,
                        input int exp_done_cyc, input bit exp_aborted, input int exp_wd);
        bit got;
        dir       = d;
        disk_base = 15'(db);
        mem_base  = 10'(mb);
        length    = 16'(len);
        abort     = abort_at_start;
        start     = 1'b1;
        t0        = cyc;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        got       = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                abort = (cyc - t0 == abort_cyc);
                start = (cyc - t0 == sp_cyc);
                tick();
            end
        end
        abort = 1'b0;
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_done_cycle"}, cyc - t0, exp_done_cyc);
        chk({tag, "_aborted"}, 32'(aborted), 32'(exp_aborted));
        chk({tag, "_words_done"}, 32'(words_done), exp_wd);
        chk({tag, "_pending"}, sb.size(), 0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_aborted_hold"}, 32'(aborted), 32'(exp_aborted));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        dir       = 1'b0;
        disk_base = 15'd0;
        mem_base  = 10'd0;
        length    = 16'd0;
        abort     = 1'b0;
        pl_en     = 1'b0;
        pl_disk   = 1'b0;
        pl_addr   = 15'd0;
        pl_data   = 16'd0;

        tick();
        tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        preload(1'b1, 0, 333);
        preload(1'b1, 16384, 444);
        preload(1'b0, 0, 10);
        preload(1'b0, 1, 11);
        preload(1'b0, 2, 12);
        preload(1'b1, 20, 555);
        preload(1'b1, 21, 777);

        // Single word disk->memory.
        push(1'b0, 5, 333, 3);
        xfer("t1_d2m", 1'b0, 0, 5, 1, 1'b0, -1, -1, 4, 1'b0, 1);

        // Three words memory->disk crossing 16384; abort together with start is ignored.
        push(1'b1, 16383, 10, 3);
        push(1'b1, 16384, 11, 6);
        push(1'b1, 16385, 12, 9);
        xfer("t2_m2d", 1'b1, 16383, 0, 3, 1'b1, -1, -1, 10, 1'b0, 3);
        chk("t2_disk16384", 32'(disk_m[16384]), 32'd11);

        // Disk pointer wraps from 32767 to 0.
        push(1'b1, 32767, 10, 3);
        push(1'b1, 0, 11, 6);
        xfer("t3_wrap", 1'b1, 32767, 0, 2, 1'b0, -1, -1, 7, 1'b0, 2);
        chk("t3_disk0", 32'(disk_m[0]), 32'd11);

        // Zero length.
        xfer("t4_len0", 1'b0, 0, 0, 0, 1'b0, -1, -1, 1, 1'b0, 0);

        // Abort during the second WRITE; stray start while busy.
        push(1'b0, 100, 555, 3);
        push(1'b0, 101, 777, 6);
        xfer("t5_abort", 1'b0, 20, 100, 4, 1'b0, 6, 2, 7, 1'b1, 2);
        chk("t5_mem102", 32'(mem_m[102]), 32'd0);

        // Reset during the WAIT of word 2.
        push(1'b0, 200, 555, 3);
        dir       = 1'b0;
        disk_base = 15'd20;
        mem_base  = 10'd200;
        length    = 16'd3;
        start     = 1'b1;
        t0        = cyc;
        tick();
        start     = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_in_wait", cyc - t0, 5);
        chk("t6_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("t6_rst");
        tick();
        tick();
        chk_zero_outputs("t6_rst_hold");
        rst_n = 1'b1;
        chk("t6_pending", sb.size(), 0);
        chk("t6_mem201", 32'(mem_m[201]), 32'd0);

        // Normal transfer after reset.
        push(1'b0, 300, 777, 3);
        xfer("t7_after_rst", 1'b0, 21, 300, 1, 1'b0, -1, -1, 4, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
